// File: rtl/aes128_enc_iter_if.sv
// Block-in / ciphertext-out handshake bundle for the iterative AES-128 encryptor.
// The core sits on the slave side; the block source and ciphertext sink sit on the master side.
interface aes128_enc_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 cipher: one round per clock with the round key expanded on the fly.
// State bytes are column-major, s[r][c] at bits [127-8*(4c+r) -: 8].
module aes128_enc_iter (
    input  logic              clk,
    input  logic              rst,
    aes128_enc_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t         fsm_q, fsm_next;
    logic [127:0] state_q, rkey_q;
    logic [3:0]   round_q;
    logic [7:0]   rcon_q;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as the affine map of the field inverse x^254 (0 maps to 0).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        inv  = gmul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]   sb_byte [16];
    logic [127:0] sr_state, mc_state, next_key, round_out;
    logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3, w4, w5, w6, w7;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_subbytes
            assign sb_byte[gi] = sbox(state_q[127-8*gi -: 8]);
        end
        // Row r rotates left by r: destination s[r][c] takes s[r][(c+r) mod 4].
        for (gi = 0; gi < 16; gi++) begin : g_shiftrows
            localparam int R = gi % 4;
            localparam int C = gi / 4;
            assign sr_state[127-8*gi -: 8] = sb_byte[4*((C+R)%4)+R];
        end
        for (gi = 0; gi < 4; gi++) begin : g_mixcol
            logic [7:0] a0, a1, a2, a3;
            assign a0 = sr_state[127-32*gi -: 8];
            assign a1 = sr_state[119-32*gi -: 8];
            assign a2 = sr_state[111-32*gi -: 8];
            assign a3 = sr_state[103-32*gi -: 8];
            assign mc_state[127-32*gi -: 32] = {
                xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
            };
        end
        for (gi = 0; gi < 4; gi++) begin : g_subword
            assign sub_w3[31-8*gi -: 8] = sbox(rot_w3[31-8*gi -: 8]);
        end
    endgenerate

    assign {w0, w1, w2, w3} = rkey_q;
    assign rot_w3   = {w3[23:0], w3[31:24]};
    assign w4       = w0 ^ sub_w3 ^ {rcon_q, 24'h000000};
    assign w5       = w4 ^ w1;
    assign w6       = w5 ^ w2;
    assign w7       = w6 ^ w3;
    assign next_key = {w4, w5, w6, w7};

    // The final round skips MixColumns.
    assign round_out = ((round_q == 4'd10) ? sr_state : mc_state) ^ next_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
            rcon_q  <= '0;
        end else begin
            fsm_q <= fsm_next;
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= bus.plaintext ^ bus.key;
                        rkey_q  <= bus.key;
                        round_q <= 4'd1;
                        rcon_q  <= 8'h01;
                    end
                end
                RUN: begin
                    state_q <= round_out;
                    rkey_q  <= next_key;
                    rcon_q  <= xtime(rcon_q);
                    if (round_q != 4'd10) round_q <= round_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fsm_next = fsm_q;
        case (fsm_q)
            IDLE:    if (bus.in_valid)         fsm_next = RUN;
            RUN:     if (round_q == 4'd10)     fsm_next = DONE;
            DONE:    if (bus.out_ready)        fsm_next = IDLE;
            default:                           fsm_next = IDLE;
        endcase
    end

    // Intermediate round state stays hidden; ciphertext is only driven while presented.
    always_comb begin
        bus.in_ready   = (fsm_q == IDLE) && !rst;
        bus.out_valid  = (fsm_q == DONE);
        bus.ciphertext = (fsm_q == DONE) ? state_q : '0;
    end
endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed FIPS-197 vectors for the iterative AES-128 encryptor: latency, backpressure,
// mid-run reset and back-to-back blocks.
module tb_aes128_enc_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes128_enc_iter_if bus ();

    aes128_enc_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts rising edges from the accept edge (inclusive) until out_valid appears.
    task automatic wait_valid(input int start, output int edges);
        edges = start;
        while (bus.out_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic accept(input logic [127:0] pt, input logic [127:0] k);
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.key       = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int   edges;
        int   t_first;
        logic bad;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
        chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("rst_ciphertext", bus.ciphertext, 128'd0);
        rst = 1'b0;
        tick();
        chk("idle_in_ready", {127'b0, bus.in_ready}, 128'd1);

        // C.1 with a stray in_valid during RUN that must be ignored
        accept(C1_PT, C1_KEY);
        chk("run_in_ready", {127'b0, bus.in_ready}, 128'd0);
        bus.in_valid  = 1'b1;
        bus.plaintext = B_PT;
        bus.key       = B_KEY;
        tick();
        tick();
        bus.in_valid = 1'b0;
        wait_valid(3, edges);
        chk("c1_out_valid", {127'b0, bus.out_valid}, 128'd1);
        chk("c1_latency_edges", 128'(edges), 128'd11);
        chk("c1_ciphertext", bus.ciphertext, C1_CT);

        // Backpressure: 20 cycles held in DONE
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ciphertext !== C1_CT || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                bad = 1'b1;
        end
        chk("hold_stable", {127'b0, bad}, 128'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("hs_out_valid_drop", {127'b0, bus.out_valid}, 128'd0);
        chk("hs_in_ready", {127'b0, bus.in_ready}, 128'd1);

        // Appendix B vector plus the last round key
        accept(B_PT, B_KEY);
        wait_valid(1, edges);
        chk("b_ciphertext", bus.ciphertext, B_CT);
        chk("b_rkey_round10", dut.rkey_q, B_RK10);
        chk("b_round_max", 128'(dut.round_q), 128'd10);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset at round 5 aborts cleanly
        accept(C1_PT, C1_KEY);
        edges = 0;
        while (dut.round_q !== 4'd5 && edges < 20) begin
            tick();
            edges++;
        end
        chk("reach_round5", 128'(dut.round_q), 128'd5);
        rst = 1'b1;
        tick();
        chk("abort_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("abort_in_ready", {127'b0, bus.in_ready}, 128'd0);
        chk("abort_ciphertext", bus.ciphertext, 128'd0);
        chk("abort_state", dut.state_q, 128'd0);
        rst = 1'b0;
        tick();

        // Re-run with a stale out_ready high while accepting
        bus.out_ready = 1'b1;
        accept(C1_PT, C1_KEY);
        bus.out_ready = 1'b0;
        wait_valid(1, edges);
        chk("rerun_latency_edges", 128'(edges), 128'd11);
        chk("rerun_ciphertext", bus.ciphertext, C1_CT);
        bus.out_ready = 1'b1;
        tick();

        // Back-to-back: in_valid held, out_ready high
        bus.plaintext = C1_PT;
        bus.key       = C1_KEY;
        bus.in_valid  = 1'b1;
        tick();
        bus.plaintext = B_PT;
        bus.key       = B_KEY;
        wait_valid(1, edges);
        t_first = cyc;
        chk("b2b_first_ct", bus.ciphertext, C1_CT);
        tick();
        wait_valid(0, edges);
        chk("b2b_second_ct", bus.ciphertext, B_CT);
        chk("b2b_gap", 128'(cyc - t_first), 128'd12);
        bus.in_valid  = 1'b0;
        tick();
        chk("b2b_end_out_valid", {127'b0, bus.out_valid}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
